axi_wr_dispatch: RTL and testbench
==================================

// Module: axi_wr_dispatch
// PURPOSE
//  Routes each write beat from the AXI write interface (one beat outstanding, WREADY held low until done) to FIFO, IRAM or WRAM by region.
//  Arbitrates IRAM/WRAM write ports between AXI beats and internal engine writes (round-robin per RAM); returns done/err pulses.
// PARAMETERS
//  ADDR_WIDTH   11   beat/RAM address width
//  DATA_WIDTH   32   write data width
//  STRB_WIDTH   4    byte strobes (DATA_WIDTH/8)
//  FIFO_TO_CYC  255  max cycles a FIFO beat waits on fifo_full before error drop
//  TO_CNT_W     8    timeout counter width (2**TO_CNT_W > FIFO_TO_CYC)
// PORTS
//  clk            in  1           clock
//  rst_n          in  1           async active-low reset
//  axi_wr_vld     in  1           1-cycle beat strobe; addr/data/strb/region valid with it
//  axi_wr_addr    in  ADDR_WIDTH  beat address
//  axi_wr_data    in  DATA_WIDTH  beat data
//  axi_wr_strb    in  STRB_WIDTH  beat strobes
//  axi_wr_region  in  2           00 FIFO, 01 IRAM, 10 WRAM, 11 invalid
//  fifo_wr_done / iram_wr_done / wram_wr_done  out 1 each  1-cycle beat completion
//  fifo_err       out 1           valid only with fifo_wr_done; 1 = SLVERR
//  eng_wr_req     in  1           engine request, level; fields stable until gnt
//  eng_wr_sel     in  1           0 IRAM, 1 WRAM
//  eng_wr_addr/eng_wr_data/eng_wr_strb  in  ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH
//  eng_wr_gnt     out 1           1-cycle pulse, coincident with RAM write
//  fifo_push      out 1           FIFO write strobe;  fifo_wdata out DATA_WIDTH
//  fifo_full      in  1           FIFO cannot accept
//  iram_we / wram_we              out 1           1-cycle RAM write enable
//  iram_addr / wram_addr          out ADDR_WIDTH
//  iram_wdata / wram_wdata        out DATA_WIDTH
//  iram_wstrb / wram_wstrb        out STRB_WIDTH
//  proto_err      out 1           sticky: axi_wr_vld while beat pending
// BEHAVIOUR
//  - Reset: every output and state register 0; FSM IDLE; both RR pointers favour AXI; pending beat discarded, no done pulse.
//  - All target-side outputs and done/gnt pulses registered.
//  - AXI FSM: IDLE, PEND, FIFO_WAIT. axi_wr_vld in IDLE latches beat -> PEND next edge.
//  - PEND, region 11: next cycle fifo_wr_done=1, fifo_err=1, no target write -> IDLE.
//  - PEND, region 00: fifo_full=0 -> next cycle fifo_push=1, fifo_wdata=data, fifo_wr_done=1, fifo_err=0 -> IDLE.
//    fifo_full=1 -> FIFO_WAIT; counter from 0, +1 per cycle full stays 1.
//  - FIFO_WAIT: push on first cycle fifo_full=0 (as above). Counter reaching FIFO_TO_CYC while full:
//    beat dropped, fifo_wr_done=1, fifo_err=1, no push -> IDLE. Counter clears on leaving.
//  - PEND, region 01/10: requests that RAM; on win, next cycle *_we=1 with latched addr/data/strb and matching *_wr_done=1 -> IDLE.
//    On loss stay PEND, re-arbitrate every cycle.
//  - Min latency axi_wr_vld -> done: 2 cycles (vld cycle T, done T+2).
//  - Engine: per cycle, eng_wr_req targets RAM eng_wr_sel. Win -> next cycle that RAM's we with eng fields, eng_wr_gnt=1.
//    req ignored in any cycle eng_wr_gnt=1 (no double grant from stale req).
//  - Arbitration per RAM, independent: single requester always wins.
//    Both request -> RR pointer side wins; pointer then moves to loser. Uncontended grant leaves pointer unchanged.
//    AXI->IRAM and engine->WRAM granted same cycle: both writes issue.
//  - Never more than one we per RAM per cycle. At most one of the three done pulses per cycle.
//  - axi_wr_vld outside IDLE: beat ignored, proto_err set (sticky until reset), pending beat unaffected.
//  - RAM/FIFO data outputs hold last value when strobes low.
// TESTING
//  1 region=01 addr=0x010 data=0xA5A5A5A5 strb=0xF, no engine -> T+2 iram_we=1 with those values, iram_wr_done=1 one cycle.
//  2 region=00, fifo_full=1 for 3 cycles then 0 -> fifo_push + fifo_wr_done, fifo_err=0 in cycle after full drops;
//    full held FIFO_TO_CYC cycles -> fifo_wr_done=1, fifo_err=1, no push.
//  3 region=11 -> T+2 fifo_wr_done=1, fifo_err=1; no push/we.
//  4 AXI WRAM beat + eng_wr_req sel=1 held every cycle -> AXI first (reset pointer);
//    eng gnt before any AXI write; contention alternates; eng_wr_gnt one cycle per request.
//  5 eng sel=0 and AXI WRAM same cycle -> iram_we and wram_we both in next cycle.
//    Second axi_wr_vld during PEND -> proto_err=1, original beat completes once.
//  6 rst_n low while FIFO_WAIT / PEND -> all outputs 0, no done pulse after release, next beat handled normally.

Source files
------------

// File: rtl/axi_wr_dispatch.sv
// axi_wr_dispatch: steers single outstanding AXI write beats to the FIFO, IRAM or
// WRAM, and shares each RAM write port between AXI beats and engine writes using
// an independent round-robin pointer per RAM. All target-side outputs are registered.
module axi_wr_dispatch #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = 4,
  parameter int FIFO_TO_CYC = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // AXI write beat side
  input  logic                  axi_wr_vld,
  input  logic [ADDR_WIDTH-1:0] axi_wr_addr,
  input  logic [DATA_WIDTH-1:0] axi_wr_data,
  input  logic [STRB_WIDTH-1:0] axi_wr_strb,
  input  logic [1:0]            axi_wr_region,
  output logic                  fifo_wr_done,
  output logic                  iram_wr_done,
  output logic                  wram_wr_done,
  output logic                  fifo_err,
  // engine write side
  input  logic                  eng_wr_req,
  input  logic                  eng_wr_sel,
  input  logic [ADDR_WIDTH-1:0] eng_wr_addr,
  input  logic [DATA_WIDTH-1:0] eng_wr_data,
  input  logic [STRB_WIDTH-1:0] eng_wr_strb,
  output logic                  eng_wr_gnt,
  // FIFO target
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  // RAM targets
  output logic                  iram_we,
  output logic [ADDR_WIDTH-1:0] iram_addr,
  output logic [DATA_WIDTH-1:0] iram_wdata,
  output logic [STRB_WIDTH-1:0] iram_wstrb,
  output logic                  wram_we,
  output logic [ADDR_WIDTH-1:0] wram_addr,
  output logic [DATA_WIDTH-1:0] wram_wdata,
  output logic [STRB_WIDTH-1:0] wram_wstrb,
  // protocol monitor
  output logic                  proto_err
);

  // RAM index 0 is IRAM (region 01, eng_wr_sel 0), index 1 is WRAM (region 10, eng_wr_sel 1)
  localparam int NRAM = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PEND      = 2'd1,
    ST_FIFO_WAIT = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  latch_beat;
  logic [ADDR_WIDTH-1:0] beat_addr_reg;
  logic [DATA_WIDTH-1:0] beat_data_reg;
  logic [STRB_WIDTH-1:0] beat_strb_reg;
  logic [1:0]            beat_region_reg;
  logic [TO_CNT_W-1:0]   cnt_reg, cnt_next;

  // pointer bit per RAM: 0 favours AXI, 1 favours the engine
  logic [NRAM-1:0]       ptr_reg, ptr_next;
  logic [NRAM-1:0]       axi_req, eng_req, axi_win, eng_win;

  logic                  fifo_push_next, fifo_done_next, fifo_err_next;
  logic                  fifo_push_reg, fifo_done_reg, fifo_err_reg;
  logic [DATA_WIDTH-1:0] fifo_wdata_reg;
  logic [NRAM-1:0]       ram_we_reg, ram_done_reg;
  logic                  eng_gnt_reg;
  logic                  proto_err_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg  [NRAM];
  logic [DATA_WIDTH-1:0] ram_wdata_reg [NRAM];
  logic [STRB_WIDTH-1:0] ram_wstrb_reg [NRAM];

  // Per-RAM arbitration and registered write port
  generate
    for (genvar gi = 0; gi < NRAM; gi++) begin : g_ram
      // a stale request in the cycle its grant is visible is not re-arbitrated
      assign axi_req[gi]  = (state_reg == ST_PEND) && (beat_region_reg == 2'(gi + 1));
      assign eng_req[gi]  = eng_wr_req && !eng_gnt_reg && (eng_wr_sel == 1'(gi));
      assign axi_win[gi]  = axi_req[gi] && (!eng_req[gi] || !ptr_reg[gi]);
      assign eng_win[gi]  = eng_req[gi] && (!axi_req[gi] ||  ptr_reg[gi]);
      // only a contended grant moves the pointer, and it moves to the loser
      assign ptr_next[gi] = (axi_req[gi] && eng_req[gi]) ? axi_win[gi] : ptr_reg[gi];

      // register the winning write; fields hold their last value otherwise
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ram_we_reg[gi]    <= 1'b0;
          ram_addr_reg[gi]  <= '0;
          ram_wdata_reg[gi] <= '0;
          ram_wstrb_reg[gi] <= '0;
        end else begin
          ram_we_reg[gi] <= axi_win[gi] | eng_win[gi];
          if (axi_win[gi]) begin
            ram_addr_reg[gi]  <= beat_addr_reg;
            ram_wdata_reg[gi] <= beat_data_reg;
            ram_wstrb_reg[gi] <= beat_strb_reg;
          end else if (eng_win[gi]) begin
            ram_addr_reg[gi]  <= eng_wr_addr;
            ram_wdata_reg[gi] <= eng_wr_data;
            ram_wstrb_reg[gi] <= eng_wr_strb;
          end
        end
      end
    end
  endgenerate

  // AXI beat FSM: next state, FIFO timeout counter and FIFO-side completion
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    latch_beat     = 1'b0;
    fifo_push_next = 1'b0;
    fifo_done_next = 1'b0;
    fifo_err_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (axi_wr_vld) begin
          latch_beat = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        case (beat_region_reg)
          2'b00: begin
            if (!fifo_full) begin
              fifo_push_next = 1'b1;
              fifo_done_next = 1'b1;
              state_next     = ST_IDLE;
            end else begin
              cnt_next   = '0;
              state_next = ST_FIFO_WAIT;
            end
          end
          2'b01: if (axi_win[0]) state_next = ST_IDLE;
          2'b10: if (axi_win[1]) state_next = ST_IDLE;
          default: begin
            // invalid region completes as SLVERR without touching any target
            fifo_done_next = 1'b1;
            fifo_err_next  = 1'b1;
            state_next     = ST_IDLE;
          end
        endcase
      end
      ST_FIFO_WAIT: begin
        if (!fifo_full) begin
          fifo_push_next = 1'b1;
          fifo_done_next = 1'b1;
          cnt_next       = '0;
          state_next     = ST_IDLE;
        end else if (cnt_reg == TO_CNT_W'(FIFO_TO_CYC)) begin
          fifo_done_next = 1'b1;
          fifo_err_next  = 1'b1;
          cnt_next       = '0;
          state_next     = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + TO_CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state, timeout counter and RR pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  // capture the beat fields when a beat is accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_addr_reg   <= '0;
      beat_data_reg   <= '0;
      beat_strb_reg   <= '0;
      beat_region_reg <= '0;
    end else if (latch_beat) begin
      beat_addr_reg   <= axi_wr_addr;
      beat_data_reg   <= axi_wr_data;
      beat_strb_reg   <= axi_wr_strb;
      beat_region_reg <= axi_wr_region;
    end
  end

  // registered completion pulses, FIFO push, grant and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_push_reg  <= 1'b0;
      fifo_done_reg  <= 1'b0;
      fifo_err_reg   <= 1'b0;
      fifo_wdata_reg <= '0;
      ram_done_reg   <= '0;
      eng_gnt_reg    <= 1'b0;
      proto_err_reg  <= 1'b0;
    end else begin
      fifo_push_reg <= fifo_push_next;
      fifo_done_reg <= fifo_done_next;
      fifo_err_reg  <= fifo_err_next;
      if (fifo_push_next) fifo_wdata_reg <= beat_data_reg;
      ram_done_reg  <= axi_win;
      eng_gnt_reg   <= |eng_win;
      proto_err_reg <= proto_err_reg | (axi_wr_vld && (state_reg != ST_IDLE));
    end
  end

  assign fifo_push    = fifo_push_reg;
  assign fifo_wdata   = fifo_wdata_reg;
  assign fifo_wr_done = fifo_done_reg;
  assign fifo_err     = fifo_err_reg;
  assign iram_wr_done = ram_done_reg[0];
  assign wram_wr_done = ram_done_reg[1];
  assign eng_wr_gnt   = eng_gnt_reg;
  assign iram_we      = ram_we_reg[0];
  assign iram_addr    = ram_addr_reg[0];
  assign iram_wdata   = ram_wdata_reg[0];
  assign iram_wstrb   = ram_wstrb_reg[0];
  assign wram_we      = ram_we_reg[1];
  assign wram_addr    = ram_addr_reg[1];
  assign wram_wdata   = ram_wdata_reg[1];
  assign wram_wstrb   = ram_wstrb_reg[1];
  assign proto_err    = proto_err_reg;

endmodule

// File: tb/tb_axi_wr_dispatch.sv
// Directed bench for axi_wr_dispatch: expected target writes are queued per target
// when stimulus is driven and checked (including arrival cycle) as the DUT emits them.
module tb_axi_wr_dispatch;

  localparam int FIFO_TO_CYC = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axi_wr_vld;
  logic [10:0] axi_wr_addr;
  logic [31:0] axi_wr_data;
  logic [3:0]  axi_wr_strb;
  logic [1:0]  axi_wr_region;
  logic        fifo_wr_done, iram_wr_done, wram_wr_done, fifo_err;
  logic        eng_wr_req, eng_wr_sel;
  logic [10:0] eng_wr_addr;
  logic [31:0] eng_wr_data;
  logic [3:0]  eng_wr_strb;
  logic        eng_wr_gnt;
  logic        fifo_push;
  logic [31:0] fifo_wdata;
  logic        fifo_full;
  logic        iram_we, wram_we;
  logic [10:0] iram_addr, wram_addr;
  logic [31:0] iram_wdata, wram_wdata;
  logic [3:0]  iram_wstrb, wram_wstrb;
  logic        proto_err;

  axi_wr_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .axi_wr_vld(axi_wr_vld), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
    .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
    .fifo_wr_done(fifo_wr_done), .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done),
    .fifo_err(fifo_err),
    .eng_wr_req(eng_wr_req), .eng_wr_sel(eng_wr_sel), .eng_wr_addr(eng_wr_addr),
    .eng_wr_data(eng_wr_data), .eng_wr_strb(eng_wr_strb), .eng_wr_gnt(eng_wr_gnt),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .iram_we(iram_we), .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_wstrb(iram_wstrb),
    .wram_we(wram_we), .wram_addr(wram_addr), .wram_wdata(wram_wdata), .wram_wstrb(wram_wstrb),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        eng;
    logic        err;
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t iram_q[$];
  exp_t wram_q[$];
  exp_t fifo_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  function automatic exp_t mk(input int c, input logic g, input logic er,
                              input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.cyc = c; e.eng = g; e.err = er; e.addr = a; e.data = d; e.strb = s;
    return e;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 160'({fifo_wr_done, iram_wr_done, wram_wr_done, fifo_err, eng_wr_gnt,
                               fifo_push, iram_we, wram_we, proto_err}), 160'(0));
    check({tag, "_data"}, 160'({fifo_wdata, iram_wdata, wram_wdata}), 160'(0));
    check({tag, "_addr"}, 160'({iram_addr, wram_addr, iram_wstrb, wram_wstrb}), 160'(0));
  endtask

  // advance one clock and score every target event produced by that edge
  task automatic step();
    exp_t e;
    logic exp_gnt;
    logic exp_push;
    @(posedge clk);
    #1;
    cyc++;
    exp_gnt  = 1'b0;
    exp_push = 1'b0;
    if (iram_we) begin
      if (iram_q.size() == 0) check("iram_unexp_we", 160'(iram_we), 160'(0));
      else begin
        e = iram_q.pop_front();
        check("iram_cyc", 160'(cyc), 160'(e.cyc));
        check("iram_addr", 160'(iram_addr), 160'(e.addr));
        check("iram_wdata", 160'(iram_wdata), 160'(e.data));
        check("iram_wstrb", 160'(iram_wstrb), 160'(e.strb));
        check("iram_done", 160'(iram_wr_done), 160'(!e.eng));
        exp_gnt = exp_gnt | e.eng;
      end
    end else check("iram_done_nowe", 160'(iram_wr_done), 160'(0));
    if (iram_q.size() > 0 && iram_q[0].cyc <= cyc) begin
      e = iram_q.pop_front();
      check("iram_missing_we", 160'(iram_we), 160'(1));
    end
    if (wram_we) begin
      if (wram_q.size() == 0) check("wram_unexp_we", 160'(wram_we), 160'(0));
      else begin
        e = wram_q.pop_front();
        check("wram_cyc", 160'(cyc), 160'(e.cyc));
        check("wram_addr", 160'(wram_addr), 160'(e.addr));
        check("wram_wdata", 160'(wram_wdata), 160'(e.data));
        check("wram_wstrb", 160'(wram_wstrb), 160'(e.strb));
        check("wram_done", 160'(wram_wr_done), 160'(!e.eng));
        exp_gnt = exp_gnt | e.eng;
      end
    end else check("wram_done_nowe", 160'(wram_wr_done), 160'(0));
    if (wram_q.size() > 0 && wram_q[0].cyc <= cyc) begin
      e = wram_q.pop_front();
      check("wram_missing_we", 160'(wram_we), 160'(1));
    end
    if (fifo_wr_done) begin
      if (fifo_q.size() == 0) check("fifo_unexp_done", 160'(fifo_wr_done), 160'(0));
      else begin
        e = fifo_q.pop_front();
        check("fifo_cyc", 160'(cyc), 160'(e.cyc));
        check("fifo_err", 160'(fifo_err), 160'(e.err));
        exp_push = !e.err;
        if (!e.err) check("fifo_wdata", 160'(fifo_wdata), 160'(e.data));
      end
    end
    if (fifo_q.size() > 0 && fifo_q[0].cyc <= cyc) begin
      e = fifo_q.pop_front();
      check("fifo_missing_done", 160'(fifo_wr_done), 160'(1));
    end
    check("fifo_push", 160'(fifo_push), 160'(exp_push));
    check("eng_gnt", 160'(eng_wr_gnt), 160'(exp_gnt));
    check("done_onehot", 160'($countones({fifo_wr_done, iram_wr_done, wram_wr_done}) <= 1), 160'(1));
  endtask

  task automatic axi_beat(input logic [1:0] r, input logic [10:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    axi_wr_vld = 1'b1; axi_wr_region = r; axi_wr_addr = a; axi_wr_data = d; axi_wr_strb = s;
    step();
    axi_wr_vld = 1'b0;
  endtask

  task automatic set_eng(input logic sel, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    eng_wr_req = 1'b1; eng_wr_sel = sel; eng_wr_addr = a; eng_wr_data = d; eng_wr_strb = s;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    axi_wr_vld = 1'b0; axi_wr_addr = '0; axi_wr_data = '0; axi_wr_strb = '0; axi_wr_region = '0;
    eng_wr_req = 1'b0; eng_wr_sel = 1'b0; eng_wr_addr = '0; eng_wr_data = '0; eng_wr_strb = '0;
    fifo_full = 1'b0;
    step(); step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // IRAM beat, minimum latency
    iram_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h010, 32'hA5A5A5A5, 4'hF));
    axi_beat(2'b01, 11'h010, 32'hA5A5A5A5, 4'hF);
    step(); step();

    // WRAM beat with partial strobes
    wram_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h7FF, 32'h12345678, 4'h5));
    axi_beat(2'b10, 11'h7FF, 32'h12345678, 4'h5);
    step(); step();

    // invalid region: SLVERR, no push, no RAM write
    fifo_q.push_back(mk(cyc + 2, 1'b0, 1'b1, 11'h0, 32'h0, 4'h0));
    axi_beat(2'b11, 11'h001, 32'hDEADBEEF, 4'hF);
    step(); step();
    check("proto_idle", 160'(proto_err), 160'(0));

    // FIFO beat with space available
    fifo_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h0, 32'h0BADF00D, 4'h0));
    axi_beat(2'b00, 11'h002, 32'h0BADF00D, 4'hF);
    step(); step();

    // FIFO beat held off by fifo_full for three cycles
    fifo_full = 1'b1;
    fifo_q.push_back(mk(cyc + 4, 1'b0, 1'b0, 11'h0, 32'hCAFE0001, 4'h0));
    axi_beat(2'b00, 11'h003, 32'hCAFE0001, 4'hF);
    step(); step();
    fifo_full = 1'b0;
    step(); step();

    // FIFO beat timed out: error completion, no push
    fifo_full = 1'b1;
    fifo_q.push_back(mk(cyc + 3 + FIFO_TO_CYC, 1'b0, 1'b1, 11'h0, 32'h0, 4'h0));
    axi_beat(2'b00, 11'h004, 32'hCAFE0002, 4'hF);
    for (int i = 0; i < FIFO_TO_CYC + 10 && fifo_q.size() > 0; i++) step();
    fifo_full = 1'b0;
    step(); step();

    // AXI->WRAM and engine->IRAM in the same cycle; second vld during PEND
    wram_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h100, 32'h55AA55AA, 4'hF));
    axi_beat(2'b10, 11'h100, 32'h55AA55AA, 4'hF);
    axi_wr_vld = 1'b1; axi_wr_region = 2'b01; axi_wr_addr = 11'h200; axi_wr_data = 32'hFFFF0000;
    set_eng(1'b0, 11'h033, 32'h13579BDF, 4'h3);
    iram_q.push_back(mk(cyc + 1, 1'b1, 1'b0, 11'h033, 32'h13579BDF, 4'h3));
    check("proto_before", 160'(proto_err), 160'(0));
    step();
    axi_wr_vld = 1'b0; eng_wr_req = 1'b0;
    check("proto_set", 160'(proto_err), 160'(1));
    step(); step();
    check("proto_sticky", 160'(proto_err), 160'(1));

    // reset while a FIFO beat waits on fifo_full: beat discarded
    fifo_full = 1'b1;
    axi_beat(2'b00, 11'h005, 32'h77777777, 4'hF);
    step();
    rst_n = 1'b0;
    #1;
    check_zero("rst_fifo_wait");
    step(); step();
    rst_n = 1'b1;
    fifo_full = 1'b0;
    step(); step(); step();

    // reset while an IRAM beat is pending: beat discarded
    axi_beat(2'b01, 11'h006, 32'h66666666, 4'hF);
    rst_n = 1'b0;
    #1;
    check_zero("rst_pend");
    step();
    rst_n = 1'b1;
    step(); step();

    // normal beat after reset
    iram_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h007, 32'h01234567, 4'h9));
    axi_beat(2'b01, 11'h007, 32'h01234567, 4'h9);
    step(); step();

    // WRAM contention from a fresh pointer: AXI, then engine, then AXI
    wram_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h0A1, 32'hA1A1A1A1, 4'hF));
    axi_beat(2'b10, 11'h0A1, 32'hA1A1A1A1, 4'hF);
    set_eng(1'b1, 11'h0E1, 32'hE1E1E1E1, 4'hC);
    wram_q.push_back(mk(cyc + 2, 1'b1, 1'b0, 11'h0E1, 32'hE1E1E1E1, 4'hC));
    step(); step();
    set_eng(1'b1, 11'h0E2, 32'hE2E2E2E2, 4'h6);
    wram_q.push_back(mk(cyc + 2, 1'b1, 1'b0, 11'h0E2, 32'hE2E2E2E2, 4'h6));
    wram_q.push_back(mk(cyc + 3, 1'b0, 1'b0, 11'h0A2, 32'hA2A2A2A2, 4'hF));
    axi_beat(2'b10, 11'h0A2, 32'hA2A2A2A2, 4'hF);
    step();
    eng_wr_req = 1'b0;
    step();
    wram_q.push_back(mk(cyc + 2, 1'b0, 1'b0, 11'h0A3, 32'hA3A3A3A3, 4'hF));
    axi_beat(2'b10, 11'h0A3, 32'hA3A3A3A3, 4'hF);
    set_eng(1'b1, 11'h0E3, 32'hE3E3E3E3, 4'h1);
    wram_q.push_back(mk(cyc + 2, 1'b1, 1'b0, 11'h0E3, 32'hE3E3E3E3, 4'h1));
    step(); step();
    eng_wr_req = 1'b0;
    step();

    // engine request held continuously: a grant every other cycle
    set_eng(1'b1, 11'h0E4, 32'hE4E4E4E4, 4'hF);
    wram_q.push_back(mk(cyc + 1, 1'b1, 1'b0, 11'h0E4, 32'hE4E4E4E4, 4'hF));
    wram_q.push_back(mk(cyc + 3, 1'b1, 1'b0, 11'h0E4, 32'hE4E4E4E4, 4'hF));
    wram_q.push_back(mk(cyc + 5, 1'b1, 1'b0, 11'h0E4, 32'hE4E4E4E4, 4'hF));
    repeat (6) step();
    eng_wr_req = 1'b0;
    step(); step();

    for (int i = 0; i < 20 && (iram_q.size() + wram_q.size() + fifo_q.size()) > 0; i++) step();
    check("queues_empty", 160'(iram_q.size() + wram_q.size() + fifo_q.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
